// File: rtl/life_pkg.sv
// Shared constants, FSM state type and saturating counter helpers for the
// life push-button front end.
package life_pkg;

    localparam int NKEYS     = 6;
    localparam int KEY_NXT   = 0;
    localparam int KEY_FLIP  = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_LEFT  = 4;
    localparam int KEY_RIGHT = 5;

    // Cursor keys auto-repeat; nxt and flip fire once per press.
    localparam logic [NKEYS-1:0] REPEAT_MASK = 6'b111100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } key_state_t;

    function automatic logic [15:0] db_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [23:0] rpt_inc(input logic [23:0] v);
        return (v == 24'hFFFFFF) ? v : v + 24'd1;
    endfunction

endpackage

// File: rtl/life_key_db.sv
// One button channel: 2-FF synchronizer, counter debouncer, press/repeat FSM
// and a registered single-cycle pulse.
module life_key_db
    import life_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES  = 16'd50000,
    parameter logic [23:0] RPT_DELAY  = 24'd6000000,
    parameter logic [23:0] RPT_RATE   = 24'd2000000,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter bit          REPEATABLE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic key,
    output logic held
);

    localparam logic RELEASED = ACTIVE_LOW;

    logic [1:0]  sync_q;
    logic        s;
    logic        lvl;
    logic [15:0] db_cnt;

    key_state_t  state_q, state_d;
    logic [23:0] rpt_cnt_q, rpt_cnt_d;
    logic        pulse_d;

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= {2{RELEASED}};
        else       sync_q <= {sync_q[0], raw};
    end

    assign s = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl    <= 1'b0;
            db_cnt <= 16'd0;
        end else if (s == lvl) begin
            db_cnt <= 16'd0;
        end else if (db_cnt >= DB_CYCLES - 16'd1) begin
            lvl    <= s;
            db_cnt <= 16'd0;
        end else begin
            db_cnt <= db_inc(db_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rpt_cnt_q <= 24'd0;
            key       <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            key       <= pulse_d;
        end
    end

    // Release is tested first so it wins over a coincident repeat expiry.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        pulse_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (lvl) begin
                    state_d   = PRESSED;
                    rpt_cnt_d = 24'd0;
                    pulse_d   = 1'b1;
                end
            end
            PRESSED: begin
                if (!lvl) begin
                    state_d   = IDLE;
                    rpt_cnt_d = 24'd0;
                end else if (REPEATABLE && rpt_cnt_q >= RPT_DELAY - 24'd1) begin
                    state_d   = REPEAT;
                    rpt_cnt_d = 24'd0;
                    pulse_d   = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_inc(rpt_cnt_q);
                end
            end
            REPEAT: begin
                if (!lvl) begin
                    state_d   = IDLE;
                    rpt_cnt_d = 24'd0;
                end else if (rpt_cnt_q >= RPT_RATE - 24'd1) begin
                    rpt_cnt_d = 24'd0;
                    pulse_d   = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_inc(rpt_cnt_q);
                end
            end
            default: begin
                state_d   = IDLE;
                rpt_cnt_d = 24'd0;
            end
        endcase
    end

    assign held = lvl;

endmodule

// File: rtl/life_keys.sv
// Six-button front end: one debounced channel per key, mapped to the
// command strobes and the debounced held-level vector.
module life_keys
    import life_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES  = 16'd50000,
    parameter logic [23:0] RPT_DELAY  = 24'd6000000,
    parameter logic [23:0] RPT_RATE   = 24'd2000000,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_nxt,
    input  logic             raw_flip,
    input  logic             raw_up,
    input  logic             raw_down,
    input  logic             raw_left,
    input  logic             raw_right,
    output logic             key_nxt,
    output logic             key_flip,
    output logic             key_up,
    output logic             key_down,
    output logic             key_left,
    output logic             key_right,
    output logic [NKEYS-1:0] keys_held
);

    logic [NKEYS-1:0] raw_vec;
    logic [NKEYS-1:0] key_vec;

    assign raw_vec[KEY_NXT]   = raw_nxt;
    assign raw_vec[KEY_FLIP]  = raw_flip;
    assign raw_vec[KEY_UP]    = raw_up;
    assign raw_vec[KEY_DOWN]  = raw_down;
    assign raw_vec[KEY_LEFT]  = raw_left;
    assign raw_vec[KEY_RIGHT] = raw_right;

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        life_key_db #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_RATE   (RPT_RATE),
            .ACTIVE_LOW (ACTIVE_LOW),
            .REPEATABLE (REPEAT_MASK[i])
        ) u_key (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_vec[i]),
            .key   (key_vec[i]),
            .held  (keys_held[i])
        );
    end

    assign key_nxt   = key_vec[KEY_NXT];
    assign key_flip  = key_vec[KEY_FLIP];
    assign key_up    = key_vec[KEY_UP];
    assign key_down  = key_vec[KEY_DOWN];
    assign key_left  = key_vec[KEY_LEFT];
    assign key_right = key_vec[KEY_RIGHT];

endmodule

// File: tb/tb_life_keys.sv
// Directed bench for life_keys with short debounce/repeat constants; a second
// instance covers the active-low button build.
module tb_life_keys;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic raw_nxt, raw_flip, raw_up, raw_down, raw_left, raw_right;
    logic key_nxt, key_flip, key_up, key_down, key_left, key_right;
    logic [5:0] keys_held;

    logic a_raw_nxt, a_raw_flip, a_raw_up, a_raw_down, a_raw_left, a_raw_right;
    logic a_key_nxt, a_key_flip, a_key_up, a_key_down, a_key_left, a_key_right;
    logic [5:0] a_keys_held;

    int checks = 0;
    int errors = 0;

    life_keys #(.DB_CYCLES(16'd4), .RPT_DELAY(24'd10), .RPT_RATE(24'd3), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset),
        .raw_nxt(raw_nxt), .raw_flip(raw_flip), .raw_up(raw_up),
        .raw_down(raw_down), .raw_left(raw_left), .raw_right(raw_right),
        .key_nxt(key_nxt), .key_flip(key_flip), .key_up(key_up),
        .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .keys_held(keys_held)
    );

    life_keys #(.DB_CYCLES(16'd4), .RPT_DELAY(24'd10), .RPT_RATE(24'd3), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset(reset),
        .raw_nxt(a_raw_nxt), .raw_flip(a_raw_flip), .raw_up(a_raw_up),
        .raw_down(a_raw_down), .raw_left(a_raw_left), .raw_right(a_raw_right),
        .key_nxt(a_key_nxt), .key_flip(a_key_flip), .key_up(a_key_up),
        .key_down(a_key_down), .key_left(a_key_left), .key_right(a_key_right),
        .keys_held(a_keys_held)
    );

    function automatic logic [5:0] keyv();
        return {key_right, key_left, key_down, key_up, key_flip, key_nxt};
    endfunction

    function automatic logic [5:0] a_keyv();
        return {a_key_right, a_key_left, a_key_down, a_key_up, a_key_flip, a_key_nxt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {raw_nxt, raw_flip, raw_up, raw_down, raw_left, raw_right} = '0;
        {a_raw_nxt, a_raw_flip, a_raw_up, a_raw_down, a_raw_left, a_raw_right} = '1;
        idle(3);
        checks++;
        if (keyv() !== 6'b0) begin errors++; $display("FAIL reset_keys got %b exp %b", keyv(), 6'b0); end
        checks++;
        if (keys_held !== 6'b0) begin errors++; $display("FAIL reset_held got %b exp %b", keys_held, 6'b0); end
        checks++;
        if (a_keys_held !== 6'b0) begin errors++; $display("FAIL reset_al_held got %b exp %b", a_keys_held, 6'b0); end
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++;
            if ({keyv(), keys_held} !== 12'b0) begin
                errors++; $display("FAIL post_reset_idle n=%0d got %b exp 0", n, {keyv(), keys_held});
            end
        end
    endtask

    task automatic test_clean_press();
        raw_nxt = 1'b1;
        for (int n = 0; n <= 35; n++) begin
            if (n == 20) raw_nxt = 1'b0;
            tick();
            checks++;
            if (key_nxt !== 1'(n == 6)) begin
                errors++; $display("FAIL nxt_pulse n=%0d got %b exp %b", n, key_nxt, (n == 6));
            end
            checks++;
            if (keys_held[0] !== 1'(n >= 5 && n < 25)) begin
                errors++; $display("FAIL nxt_held n=%0d got %b exp %b", n, keys_held[0], (n >= 5 && n < 25));
            end
            checks++;
            if ((keyv() & 6'b111110) !== 6'b0) begin
                errors++; $display("FAIL nxt_others n=%0d got %b exp 0", n, keyv());
            end
        end
    endtask

    task automatic test_bounce();
        for (int n = 0; n <= 45; n++) begin
            raw_flip = (n < 30) ? ((n / 2) % 2 == 1) : 1'b1;
            tick();
            checks++;
            if (key_flip !== 1'(n == 36)) begin
                errors++; $display("FAIL flip_pulse n=%0d got %b exp %b", n, key_flip, (n == 36));
            end
        end
        raw_flip = 1'b0;
        idle(15);
    endtask

    task automatic test_repeat();
        logic exp;
        raw_right = 1'b1;
        for (int n = 0; n <= 55; n++) begin
            if (n == 40) raw_right = 1'b0;
            tick();
            exp = (n == 6) || (n >= 16 && n <= 43 && (n - 16) % 3 == 0);
            checks++;
            if (key_right !== exp) begin
                errors++; $display("FAIL right_repeat n=%0d got %b exp %b", n, key_right, exp);
            end
            if (n == 44 || n == 45) begin
                checks++;
                if (keys_held[5] !== 1'(n == 44)) begin
                    errors++; $display("FAIL right_held n=%0d got %b exp %b", n, keys_held[5], (n == 44));
                end
            end
        end
        idle(10);
    endtask

    task automatic test_simultaneous();
        raw_up   = 1'b1;
        raw_left = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            if (n == 8) begin raw_up = 1'b0; raw_left = 1'b0; end
            tick();
            checks++;
            if (keyv() !== ((n == 6) ? 6'b010100 : 6'b000000)) begin
                errors++; $display("FAIL up_left_pulse n=%0d got %b exp %b", n, keyv(),
                                   ((n == 6) ? 6'b010100 : 6'b000000));
            end
        end
        idle(10);
    endtask

    task automatic test_reset_mid_press();
        logic exp;
        raw_down = 1'b1;
        for (int n = 0; n <= 45; n++) begin
            reset = (n == 18);
            tick();
            exp = (n == 6) || (n == 16) || (n == 25) || (n == 35) || (n == 38) ||
                  (n == 41) || (n == 44);
            checks++;
            if (key_down !== exp) begin
                errors++; $display("FAIL down_reset_pulse n=%0d got %b exp %b", n, key_down, exp);
            end
            if (n == 17) begin
                checks++;
                if (keys_held !== 6'b001000) begin
                    errors++; $display("FAIL down_held_pre n=%0d got %b exp %b", n, keys_held, 6'b001000);
                end
            end
            if (n == 18) begin
                checks++;
                if ({keyv(), keys_held} !== 12'b0) begin
                    errors++; $display("FAIL down_after_reset got %b exp 0", {keyv(), keys_held});
                end
            end
        end
        reset    = 1'b0;
        raw_down = 1'b0;
        idle(15);
    endtask

    task automatic test_active_low();
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++;
            if ({a_keyv(), a_keys_held} !== 12'b0) begin
                errors++; $display("FAIL al_idle n=%0d got %b exp 0", n, {a_keyv(), a_keys_held});
            end
        end
        a_raw_nxt = 1'b0;
        for (int n = 0; n <= 15; n++) begin
            tick();
            checks++;
            if (a_keyv() !== ((n == 6) ? 6'b000001 : 6'b000000)) begin
                errors++; $display("FAIL al_nxt_pulse n=%0d got %b exp %b", n, a_keyv(),
                                   ((n == 6) ? 6'b000001 : 6'b000000));
            end
        end
        a_raw_nxt = 1'b1;
        idle(10);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        idle(10);
        test_bounce();
        test_repeat();
        test_simultaneous();
        test_reset_mid_press();
        test_active_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_keys.md
Name: life_keys

Overview:
- Input-side front end for the life top level: turns six raw, bouncy, asynchronous push-button levels into clean single-cycle command pulses.
- Drives key_nxt, key_flip, key_up, key_down, key_left and key_right, which the top level consumes as strobes.
- Per key: 2-FF synchronizer, counter-based debouncer, press-edge pulse generator.
- Cursor keys add hold-to-auto-repeat so the cursor can sweep the X×Y board.

Parameters:
- DB_CYCLES, 16'd50000, consecutive stable synchronized samples required to accept a level change (≥2).
- RPT_DELAY, 24'd6000000, cycles a repeatable key must stay debounced-pressed before the first repeat pulse (≥2).
- RPT_RATE, 24'd2000000, cycles between subsequent repeat pulses (≥2).
- ACTIVE_LOW, 1'b0, 1 = raw buttons read 0 when pressed; inverted after synchronization.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- raw_nxt, input, 1, async button: advance one generation.
- raw_flip, input, 1, async button: toggle cell under cursor.
- raw_up, input, 1, async button: cursor up.
- raw_down, input, 1, async button: cursor down.
- raw_left, input, 1, async button: cursor left.
- raw_right, input, 1, async button: cursor right.
- key_nxt, output, 1, one-cycle pulse; never repeats.
- key_flip, output, 1, one-cycle pulse; never repeats.
- key_up, output, 1, one-cycle pulse; auto-repeats.
- key_down, output, 1, one-cycle pulse; auto-repeats.
- key_left, output, 1, one-cycle pulse; auto-repeats.
- key_right, output, 1, one-cycle pulse; auto-repeats.
- keys_held, output, 6, debounced pressed levels {right,left,down,up,flip,nxt}.

Behaviour:
- Reset (sync, active-high): all key_* = 0 and keys_held = 0. All synchronizer flops hold the released level. All counters = 0. Every key FSM = IDLE.
- Reset asserted mid-press: state is forced to the above values. A button still held after reset deasserts must debounce again before it can pulse.
- Synchronizer: two flops per key, then optional inversion, giving the signal s. Latency 2 cycles.
- Debounce, per key:
  - db_cnt increments while s differs from the debounced level lvl.
  - db_cnt clears to 0 in any cycle where s equals lvl.
  - When db_cnt == DB_CYCLES-1 and s still differs, lvl takes s and db_cnt clears.
  - Glitches shorter than DB_CYCLES samples are ignored.
- Press pulse: the key_* output is registered and is high for exactly the one cycle after lvl goes 0→1.
- Latency: a clean raw press sampled first at edge 0 gives the pulse in cycle DB_CYCLES+2. No pulse on release.
- FSM per key: IDLE, PRESSED, REPEAT.
  - IDLE→PRESSED on lvl rise; emit pulse; rpt_cnt = 0.
  - PRESSED: rpt_cnt increments each cycle. For cursor keys, at rpt_cnt == RPT_DELAY-1: emit pulse, clear rpt_cnt, go to REPEAT.
  - REPEAT: at rpt_cnt == RPT_RATE-1: emit pulse, clear rpt_cnt.
  - Any state→IDLE on lvl fall, same cycle, with no pulse that cycle. Release takes priority over a coincident repeat expiry.
  - key_nxt and key_flip never leave PRESSED until release.
- Keys are fully independent. Simultaneous presses yield simultaneous pulses. Ordering and arbitration are left to downstream logic.
- Counter widths: db_cnt is 16 bits, rpt_cnt is 24 bits. Parameters must fit these widths. Counters saturate and never wrap.
- keys_held equals lvl per key. It is registered with the same timing as lvl.

Decomposition:
- Shared package life_pkg holds:
  - key index constants KEY_NXT=0, KEY_FLIP=1, KEY_UP=2, KEY_DOWN=3, KEY_LEFT=4, KEY_RIGHT=5;
  - NKEYS=6;
  - REPEAT_MASK=6'b111100;
  - the FSM state typedef (IDLE/PRESSED/REPEAT).
- One sub-module, life_key_db, implements one key: synchronizer, debouncer, FSM, pulse.
- life_keys instantiates life_key_db six times via generate, with a REPEATABLE parameter taken from REPEAT_MASK, and maps the results to ports.

Test Plan (DB_CYCLES=4, RPT_DELAY=10, RPT_RATE=3, ACTIVE_LOW=0):
- Clean press of raw_nxt held 20 cycles → key_nxt high exactly 1 cycle at cycle 6 after the first sampled edge. No further pulses. keys_held[0]=1 until 6 cycles after release.
- raw_flip toggles every 2 cycles for 30 cycles, then settles high → no pulse during bouncing. Exactly one key_flip pulse 6 cycles after settling.
- raw_right held 40 cycles → pulses at offsets 0, 10, 13, 16, … relative to the first pulse. No pulse after the debounced release.
- raw_up and raw_left pressed on the same cycle → key_up and key_left pulse in the same cycle. The other four outputs stay 0.
- Reset asserted for 1 cycle while raw_down is held in REPEAT → all outputs 0 the cycle after reset. Re-pulse 6 cycles after reset deasserts. Repeat timing restarts from RPT_DELAY.
- ACTIVE_LOW=1 build with all raw=1 idle → no pulses. Driving raw_nxt=0 produces one pulse at cycle 6.
